// File: rtl/scrambler_cfg_pkg.sv
// Shared constants for the scrambler key scheduler: ROM layout, BT.656 timing
// reference words and the scheduler state encoding.
package scrambler_cfg_pkg;

  localparam int MODE_ADDR  = 0;
  localparam int COUNT_ADDR = 1;
  localparam int KEY_BASE   = 2;
  localparam int KEY_BYTES  = 32;

  localparam logic [9:0] PRE0 = 10'h3FF;
  localparam logic [9:0] PRE1 = 10'h000;
  localparam logic [9:0] PRE2 = 10'h000;
  localparam int XY_F_BIT = 8;

  typedef enum logic [2:0] {
    BOOT_MODE = 3'd0,
    BOOT_CNT  = 3'd1,
    LOAD      = 3'd2,
    ARM       = 3'd3,
    PREFETCH  = 3'd4,
    WAIT      = 3'd5
  } sched_state_e;

  // A zero count still means one usable key; anything above the slot count is capped.
  function automatic logic [7:0] clamp_key_count(input logic [7:0] n, input int max_keys);
    if (n == 8'd0) return 8'd1;
    if (int'(n) > max_keys) return 8'(max_keys);
    return n;
  endfunction

endpackage

// File: rtl/bt656_frame_detect.sv
// Snoops a BT.656 stream for 3FF,000,000,XY preambles and strobes one cycle
// after an XY word that moves F from 1 to 0 (start of a new frame).
module bt656_frame_detect
  import scrambler_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] stream,
  output logic       boundary
);

  logic [1:0] slot;
  logic       last_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot     <= 2'd0;
      last_f   <= 1'b0;
      boundary <= 1'b0;
    end else begin
      boundary <= 1'b0;
      case (slot)
        2'd0: slot <= (stream == PRE0) ? 2'd1 : 2'd0;
        2'd1: begin
          if (stream == PRE1)      slot <= 2'd2;
          else if (stream == PRE0) slot <= 2'd1;
          else                     slot <= 2'd0;
        end
        2'd2: begin
          // A fresh 3FF here is treated as the start of a new preamble.
          if (stream == PRE2)      slot <= 2'd3;
          else if (stream == PRE0) slot <= 2'd1;
          else                     slot <= 2'd0;
        end
        default: begin
          if (stream[9]) begin
            last_f   <= stream[XY_F_BIT];
            boundary <= last_f & ~stream[XY_F_BIT];
            slot     <= 2'd0;
          end else begin
            slot <= (stream == PRE0) ? 2'd1 : 2'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/scrambler_key_scheduler.sv
// Boots mode and keys from the config ROM, then rotates the scrambler seed on
// frame boundaries, prefetching the next key into a shadow register.
module scrambler_key_scheduler
  import scrambler_cfg_pkg::*;
#(
  parameter int ROM_ADDR_W     = 8,
  parameter int MAX_KEYS       = 4,
  parameter int FRAMES_PER_KEY = 16,
  parameter int RST_PULSE      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [9:0]            bt656_stream_in,
  input  logic [7:0]            q,
  output logic [ROM_ADDR_W-1:0] address,
  output logic [255:0]          seed,
  output logic                  mode,
  output logic                  reset_n_scrambler,
  output logic [1:0]            key_index,
  output logic                  key_swap,
  output logic                  prefetch_miss,
  output sched_state_e          dbg_state
);

  localparam int FC_W = $clog2(FRAMES_PER_KEY + 1);
  localparam int RC_W = $clog2(RST_PULSE + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_KEY - 1);
  localparam logic [5:0]      LD_LAST = 6'(KEY_BYTES);

  sched_state_e    state;
  logic [5:0]      ld_cnt;
  logic [4:0]      ld_byte;
  logic            ld_done;
  logic [255:0]    shadow;
  logic            shadow_valid;
  logic [7:0]      n_keys;
  logic [1:0]      next_idx;
  logic [1:0]      after_next;
  logic [FC_W-1:0] frame_cnt;
  logic [RC_W-1:0] rst_cnt;
  logic            boundary;

  function automatic logic [1:0] succ(input logic [1:0] k, input logic [7:0] n);
    return (({6'd0, k} + 8'd1) >= n) ? 2'd0 : k + 2'd1;
  endfunction

  function automatic logic [ROM_ADDR_W-1:0] key_addr(input logic [1:0] k);
    return ROM_ADDR_W'(KEY_BASE + KEY_BYTES * int'(k));
  endfunction

  // Loader step 0 only presents the address; steps 1..32 capture bytes 0..31.
  assign ld_byte    = 5'(ld_cnt - 6'd1);
  assign ld_done    = (ld_cnt == LD_LAST);
  assign after_next = succ(next_idx, n_keys);
  assign dbg_state  = state;

  bt656_frame_detect u_detect (
    .clk      (clk),
    .reset_n  (reset_n),
    .stream   (bt656_stream_in),
    .boundary (boundary)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= BOOT_MODE;
      address           <= ROM_ADDR_W'(MODE_ADDR);
      seed              <= '0;
      mode              <= 1'b0;
      reset_n_scrambler <= 1'b0;
      key_index         <= 2'd0;
      key_swap          <= 1'b0;
      prefetch_miss     <= 1'b0;
      ld_cnt            <= 6'd0;
      shadow            <= '0;
      shadow_valid      <= 1'b0;
      n_keys            <= 8'd1;
      next_idx          <= 2'd0;
      frame_cnt         <= '0;
      rst_cnt           <= '0;
    end else begin
      key_swap <= 1'b0;
      if (rst_cnt != '0) begin
        rst_cnt <= rst_cnt - RC_W'(1);
        if (rst_cnt == RC_W'(1)) reset_n_scrambler <= 1'b1;
      end

      case (state)
        BOOT_MODE: begin
          if (ld_cnt == 6'd0) begin
            address <= ROM_ADDR_W'(COUNT_ADDR);
            ld_cnt  <= 6'd1;
          end else begin
            mode  <= q[0];
            state <= BOOT_CNT;
          end
        end
        BOOT_CNT: begin
          n_keys  <= clamp_key_count(q, MAX_KEYS);
          address <= ROM_ADDR_W'(KEY_BASE);
          ld_cnt  <= 6'd0;
          state   <= LOAD;
        end
        LOAD, PREFETCH: begin
          if (ld_cnt != 6'd0) shadow[{ld_byte, 3'b000} +: 8] <= q;
          address <= address + ROM_ADDR_W'(1);
          ld_cnt  <= ld_cnt + 6'd1;
          if (ld_done) begin
            if (state == LOAD) begin
              state <= ARM;
            end else begin
              shadow_valid <= 1'b1;
              state        <= WAIT;
            end
          end
        end
        ARM: begin
          seed      <= shadow;
          key_index <= 2'd0;
          if (boundary) begin
            reset_n_scrambler <= 1'b1;
            frame_cnt         <= '0;
            next_idx          <= succ(2'd0, n_keys);
            address           <= key_addr(succ(2'd0, n_keys));
            ld_cnt            <= 6'd0;
            state             <= PREFETCH;
          end
        end
        default: ;
      endcase

      // Frames are counted during the prefetch too; the count parks at the
      // swap value until the shadow key is ready.
      if (boundary && (state == PREFETCH || state == WAIT)) begin
        if (frame_cnt != FC_LAST) begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end else if (shadow_valid) begin
          seed              <= shadow;
          key_index         <= next_idx;
          key_swap          <= 1'b1;
          reset_n_scrambler <= 1'b0;
          rst_cnt           <= RC_W'(RST_PULSE);
          frame_cnt         <= '0;
          shadow_valid      <= 1'b0;
          next_idx          <= after_next;
          address           <= key_addr(after_next);
          ld_cnt            <= 6'd0;
          state             <= PREFETCH;
        end else begin
          prefetch_miss <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scrambler_key_scheduler.sv
// Randomized bench for the key scheduler: a ROM model, a frame-level reference
// model feeding an expected-swap queue, and a monitor that checks every swap.
module tb_scrambler_key_scheduler;
  import scrambler_cfg_pkg::*;

  localparam int FPK  = 2;
  localparam int RSTP = 4;
  localparam int MAXK = 4;
  localparam int AW   = 8;
  localparam int W    = 258;
  localparam logic [255:0] KEY0_SEQ =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [9:0]    stream;
  logic [7:0]    q;
  logic [AW-1:0] address;
  logic [255:0]  seed;
  logic          mode;
  logic          reset_n_scrambler;
  logic [1:0]    key_index;
  logic          key_swap;
  logic          prefetch_miss;
  sched_state_e  dbg_state;

  logic [7:0]    rom [256];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_item;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;

  // reference model state
  int            m_n;
  int            m_cur;
  int            m_frame;
  int            m_last;
  bit            m_armed;
  bit            m_miss;
  logic [255:0]  m_keys [4];

  scrambler_key_scheduler #(
    .ROM_ADDR_W(AW), .MAX_KEYS(MAXK), .FRAMES_PER_KEY(FPK), .RST_PULSE(RSTP)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .bt656_stream_in   (stream),
    .q                 (q),
    .address           (address),
    .seed              (seed),
    .mode              (mode),
    .reset_n_scrambler (reset_n_scrambler),
    .key_index         (key_index),
    .key_swap          (key_swap),
    .prefetch_miss     (prefetch_miss),
    .dbg_state         (dbg_state)
  );

  // clock, ROM and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) begin
    q   <= rom[address];
    cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_rom(input bit md, input logic [7:0] nraw, input bit seq_key0);
    for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
    rom[0] = {7'($urandom), md};
    rom[1] = nraw;
    if (seq_key0) for (int i = 0; i < 32; i++) rom[2 + i] = 8'(i);
    m_n = (nraw == 8'd0) ? 1 : ((int'(nraw) > MAXK) ? MAXK : int'(nraw));
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 32; i++) m_keys[k][8*i +: 8] = rom[2 + 32*k + i];
  endtask

  task automatic apply_reset(input bit md, input logic [7:0] nraw, input bit seq_key0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    load_rom(md, nraw, seq_key0);
    m_armed = 1'b0;
    m_miss  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_values();
    check("rst_address", address, 0);
    check("rst_seed", seed, 0);
    check("rst_mode", mode, 0);
    check("rst_scr_reset", reset_n_scrambler, 0);
    check("rst_key_index", key_index, 0);
    check("rst_key_swap", key_swap, 0);
    check("rst_miss", prefetch_miss, 0);
    check("rst_state", dbg_state, BOOT_MODE);
  endtask

  // driver
  task automatic put_word(input logic [9:0] w);
    @(negedge clk);
    stream = w;
  endtask

  task automatic put_filler();
    put_word(10'($urandom_range(16, 1007)));
  endtask

  task automatic put_xy(input bit f);
    put_word(10'h200 | (10'(f) << 8) | 10'($urandom_range(0, 127)));
  endtask

  // Frame rule: first F1->0 boundary arms; every FPK boundaries rotate the key,
  // provided the 33-cycle key load that started at the previous swap is finished.
  task automatic model_boundary(output bit swapped);
    int nxt;
    swapped = 1'b0;
    if (!m_armed) begin
      m_armed = 1'b1;
      m_cur   = 0;
      m_frame = 0;
      m_last  = cyc;
    end else if (m_frame != FPK - 1) begin
      m_frame++;
    end else if (cyc - m_last >= 34) begin
      nxt = (m_cur + 1) % m_n;
      exp_q.push_back({2'(nxt), m_keys[nxt]});
      m_cur   = nxt;
      m_frame = 0;
      m_last  = cyc;
      swapped = 1'b1;
    end else begin
      m_miss = 1'b1;
    end
  endtask

  // variant 0: plain preamble; 1: 3FF in the middle slot; 2: broken preamble (no boundary)
  task automatic send_frame(input int variant, input int gap_else, input int gap_swap,
                            output bit swapped);
    put_word(10'h3FF); put_word(10'h000); put_word(10'h000); put_xy(1'b1);
    put_filler(); put_filler();
    case (variant)
      0: begin put_word(10'h3FF); put_word(10'h000); put_word(10'h000); end
      1: begin
        put_word(10'h3FF); put_word(10'h000); put_word(10'h3FF);
        put_word(10'h000); put_word(10'h000);
      end
      default: begin
        put_word(10'h3FF); put_word(10'h000); put_word(10'h123); put_word(10'h000);
      end
    endcase
    put_xy(1'b0);
    swapped = 1'b0;
    if (variant != 2) model_boundary(swapped);
    repeat (swapped ? gap_swap : gap_else) put_filler();
  endtask

  // scoreboard monitor
  bit in_pulse  = 1'b0;
  bit prev_swap = 1'b0;
  int low_cnt   = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      in_pulse  = 1'b0;
      prev_swap = 1'b0;
    end else begin
      if (prev_swap) check("key_swap_width", key_swap, 0);
      if (in_pulse) begin
        if (!reset_n_scrambler) low_cnt++;
        else begin
          check("rst_pulse_len", low_cnt, RSTP);
          in_pulse = 1'b0;
        end
      end
      if (key_swap) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_swap: got key_index %0d, expected no swap", key_index);
        end else begin
          exp_item = exp_q.pop_front();
          check("swap_key", {key_index, seed}, exp_item);
        end
        check("rst_low_at_swap", reset_n_scrambler, 0);
        in_pulse = 1'b1;
        low_cnt  = 1;
      end
      prev_swap = key_swap;
    end
  end

  initial begin
    bit sw;
    stream  = 10'h040;
    reset_n = 1'b1;
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    #3 reset_n = 1'b0;
    load_rom(1'b1, 8'd2, 1'b1);
    m_armed = 1'b0;
    m_miss  = 1'b0;
    @(negedge clk);
    check_reset_values();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // boot with mode=1, N=2, key0 = 00..1F, then five long frames
    repeat (60) @(negedge clk);
    check("boot_mode", mode, 1);
    check("boot_seed", seed, KEY0_SEQ);
    check("boot_scr_held", reset_n_scrambler, 0);
    check("boot_key_index", key_index, 0);
    send_frame(0, 50, 50, sw);
    check("arm_released", reset_n_scrambler, 1);
    check("arm_seed", seed, KEY0_SEQ);
    for (int f = 0; f < 5; f++) send_frame($urandom_range(0, 2), 50, 50, sw);
    check("s1_key_index", key_index, m_cur);
    check("s1_no_miss", prefetch_miss, 0);

    // boundaries arriving faster than the key load
    for (int f = 0; f < 4 && !sw; f++) send_frame(0, 50, 0, sw);
    send_frame(0, 0, 0, sw);
    send_frame(0, 70, 70, sw);
    check("miss_model", m_miss, 1);
    check("miss_sticky", prefetch_miss, 1);
    send_frame(0, 50, 50, sw);
    check("miss_swapped_late", sw, 1);
    check("miss_key_index", key_index, m_cur);

    // reset in the middle of a prefetch, then re-boot the same ROM
    sw = 1'b0;
    for (int f = 0; f < 4 && !sw; f++) send_frame(0, 50, 0, sw);
    repeat (12) @(negedge clk);
    check("pre_reset_state", dbg_state, PREFETCH);
    check("pre_reset_drained", exp_q.size(), 0);
    #2 reset_n = 1'b0;
    #1 check_reset_values();
    m_armed = 1'b0;
    m_miss  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("reboot_seed", seed, KEY0_SEQ);
    check("reboot_mode", mode, 1);
    check("reboot_scr_held", reset_n_scrambler, 0);

    // N=0 behaves as a single key reloaded on every rotation
    apply_reset(1'b0, 8'd0, 1'b0);
    repeat (60) @(negedge clk);
    check("n0_mode", mode, 0);
    check("n0_seed", seed, m_keys[0]);
    send_frame(0, 50, 50, sw);
    for (int f = 0; f < 5; f++) send_frame($urandom_range(0, 1), 50, 50, sw);
    check("n0_key_index", key_index, 0);

    // N=7 is capped to four keys
    apply_reset(1'b1, 8'd7, 1'b0);
    repeat (60) @(negedge clk);
    check("n7_seed", seed, m_keys[0]);
    send_frame(0, 50, 50, sw);
    for (int f = 0; f < 12; f++) send_frame($urandom_range(0, 2), 50, 50, sw);
    check("n7_key_index", key_index, m_cur);
    check("n7_no_miss", prefetch_miss, 0);

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
